data_mem_bridge: RTL and testbench
==================================

// Module: data_mem_bridge
// PURPOSE
//  Responder side of the MEM-stage data-memory request bus (ce/we/addr/sel/wdata -> rdata).
//  Converts one 32-bit request into byte-serial accesses on an 8-bit synchronous RAM port.
//  Returns the word to the MEM stage and holds the pipeline (stall_req) until the access completes.
//  Sits between the MEM stage and the board byte-wide data RAM.
// PARAMETERS
//  ADDR_W   17  byte-address width of the RAM port
//  RAM_LAT  1   cycles from ram_addr presented to ram_rdata valid (legal 1..3)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       reset: synchronous, active-high
//  req_ce     in   1       request valid; held stable by the MEM stage while stall_req=1
//  req_we     in   1       1=store, 0=load
//  req_addr   in   32      byte address from the MEM stage
//  req_sel    in   4       store byte-lane mask (lane n = bits 8n+7:8n); ignored on loads
//  req_wdata  in   32      store data, already lane-replicated by the MEM stage
//  rsp_rdata  out  32      loaded word, little-endian: lane n = byte at base+n
//  rsp_ack    out  1       one-cycle completion pulse
//  rsp_fault  out  1       access rejected (see CONFIGURATION); valid with rsp_ack
//  stall_req  out  1       req_ce & ~rsp_ack (combinational)
//  ram_addr   out  ADDR_W  registered byte address
//  ram_we     out  1       registered byte write strobe
//  ram_wdata  out  8       registered byte write data
//  ram_rdata  in   8       read byte, valid RAM_LAT cycles after its address
// BEHAVIOUR
//  Reset: state=IDLE; rsp_rdata=0, rsp_ack=0, rsp_fault=0, ram_addr=0, ram_we=0, ram_wdata=0.
//  base = {req_addr[ADDR_W-1:2],2'b00}; lane addresses are base+0..base+3. No carry past the word.
//  FSM: IDLE -> RD | WR | DONE; RD -> DONE; WR -> DONE; DONE -> IDLE.
//  IDLE: req_ce=1 accepted in cycle T0. Load -> RD. Store with sel!=0 -> WR. Store with sel=0 -> DONE.
//  RD: ram_addr = base+0..3 in T1..T4.
//    Byte k is captured from ram_rdata in cycle T(1+k)+RAM_LAT.
//    DONE is entered in T5+RAM_LAT.
//  WR: selected lanes only, ascending, one per cycle, starting T1.
//    ram_we=1 with ram_addr=base+n and ram_wdata=req_wdata[8n+7:8n].
//    DONE follows the cycle after the last lane. Unselected lanes are skipped with no idle cycle.
//  DONE: rsp_ack=1 for exactly one cycle, then IDLE.
//    rsp_rdata is updated only by loads and holds its value otherwise.
//    The MEM stage advances on the clock edge ending DONE. A request seen in IDLE afterwards is a new request.
//  ram_we=0 in every state except an active WR lane cycle.
//  ram_addr holds its last value when no access is in progress.
//  Latency, load: ack at T5+RAM_LAT. Store: ack at T(1+popcount(sel)).
//  req_ce dropping mid-access is illegal; the access completes anyway.
//  rst mid-access: IDLE on the next edge, ram_we=0. Bytes already written stay written.
//    Read data in flight is discarded.
// CONFIGURATION
//  DMEM_FAULT_EN defined: an access faults if either condition holds.
//    - Its address has any of bits 31:ADDR_W set.
//    - It is a store whose sel is not one of 0001/0010/0100/1000/0011/1100/1111.
//    A faulting access goes IDLE->DONE directly: no RAM cycle, rsp_fault=1 with rsp_ack.
//    rsp_rdata is unchanged.
//  DMEM_FAULT_EN undefined: no checks. rsp_fault is tied 0.
//    Upper address bits are ignored, and any non-zero sel is written lane-by-lane.
// STRUCTURE
//  defines.v: `DmemStateBus and the encodings `DMEM_IDLE/`DMEM_RD/`DMEM_WR/`DMEM_DONE;
//    `DmemByteBus (7:0).
//  Sub-module dmem_rd_pipe: a RAM_LAT-deep shift register of {valid, lane[1:0]}.
//    It tags each issued read address so the FSM knows which lane ram_rdata belongs to.
// TESTING
//  1. RAM_LAT=1, RAM[0x100..0x103]=11,22,33,44; load 0x102.
//     -> ram_addr 0x100..0x103 in T1..T4, ack at T6, rsp_rdata=0x44332211.
//  2. Store addr 0x205, sel=0010, wdata=0xA5A5A5A5.
//     -> one ram_we at 0x205 with data A5 in T1, ack at T2. RAM 0x204/0x206/0x207 untouched.
//  3. Store sel=1111, wdata=0xDEADBEEF at 0x40.
//     -> EF,BE,AD,DE written to 0x40..0x43 in T1..T4, ack at T5. Reload returns 0xDEADBEEF.
//  4. RAM_LAT=3, load right after 3.
//     -> ack at T8, stall_req=1 from T0 through T7, rsp_rdata=0xDEADBEEF.
//  5. rst asserted in T2 of a sel=1111 store.
//     -> ram_we=0 from the next cycle. Only lanes 0..1 written, no ack. Next request handled normally.
//  6. DMEM_FAULT_EN: store sel=0110, or load 0xFFFF0000 with ADDR_W=17.
//     -> ack at T1, rsp_fault=1, no ram_we, rsp_rdata unchanged.

Source files
------------

// File: rtl/data_mem_bridge_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory bridge.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_RD,
    DMEM_WR,
    DMEM_DONE
  } dmem_state_e;

  typedef logic [7:0] dmem_byte_t;

  // Tag travelling alongside an issued read address until its byte returns.
  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
  } dmem_rd_tag_t;

  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    if (mask[0]) return 2'd0;
    if (mask[1]) return 2'd1;
    if (mask[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [3:0] lane_bit(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic dmem_byte_t lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bridge_rd_pipe.sv
// dmem_rd_pipe: RAM_LAT-deep tag delay line; its output names the lane that ram_rdata carries.
module dmem_rd_pipe
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  dmem_rd_tag_t tag_in,
  output dmem_rd_tag_t tag_out
);

  dmem_rd_tag_t stage [RAM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < RAM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RAM_LAT-1];

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: serialises one 32-bit MEM-stage request into byte accesses on an 8-bit RAM.
// Define DMEM_FAULT_EN to reject out-of-range addresses and unsupported store masks.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_sel,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_ack,
  output logic              rsp_fault,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  dmem_state_e  state, state_nxt;
  logic         fault;
  logic         iss_valid;
  logic [1:0]   iss_lane;
  logic [3:0]   wr_mask;
  logic [1:0]   wr_lane;
  logic [23:0]  rd_buf;
  dmem_rd_tag_t tag_in, tag_out;

`ifdef DMEM_FAULT_EN
  logic fault_q;
  logic unused_addr;

  assign fault       = (|req_addr[31:ADDR_W]) | (req_we & ~sel_legal(req_sel));
  assign rsp_fault   = (state == DMEM_DONE) & fault_q;
  assign unused_addr = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst)                               fault_q <= 1'b0;
    else if (state == DMEM_IDLE && req_ce) fault_q <= fault;
  end
`else
  logic unused_addr;

  assign fault       = 1'b0;
  assign rsp_fault   = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_W], req_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= DMEM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DMEM_IDLE: begin
        if (req_ce) begin
          if (fault)                state_nxt = DMEM_DONE;
          else if (!req_we)         state_nxt = DMEM_RD;
          else if (req_sel == '0)   state_nxt = DMEM_DONE;
          else                      state_nxt = DMEM_WR;
        end
      end
      DMEM_RD:   if (tag_out.valid && tag_out.lane == 2'd3) state_nxt = DMEM_DONE;
      DMEM_WR:   if (wr_mask == '0) state_nxt = DMEM_DONE;
      DMEM_DONE: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  always_comb begin
    rsp_ack       = (state == DMEM_DONE);
    stall_req     = req_ce & ~rsp_ack;
    tag_in.valid  = (state == DMEM_RD) & iss_valid;
    tag_in.lane   = iss_lane;
  end

  // First lane comes straight from req_sel; later lanes from the remaining mask.
  always_comb begin
    wr_lane = lowest_lane((state == DMEM_IDLE) ? req_sel : wr_mask);
  end

  dmem_rd_pipe #(
    .RAM_LAT(RAM_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      iss_valid <= 1'b0;
      iss_lane  <= '0;
      wr_mask   <= '0;
      rd_buf    <= '0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        DMEM_IDLE: begin
          if (req_ce && !fault && !req_we) begin
            ram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            iss_valid <= 1'b1;
            iss_lane  <= 2'd0;
          end else if (req_ce && !fault && req_sel != '0) begin
            ram_addr  <= {req_addr[ADDR_W-1:2], wr_lane};
            ram_we    <= 1'b1;
            ram_wdata <= lane_byte(req_wdata, wr_lane);
            wr_mask   <= req_sel & ~lane_bit(wr_lane);
          end
        end
        DMEM_RD: begin
          if (iss_valid) begin
            if (iss_lane == 2'd3) begin
              iss_valid <= 1'b0;
            end else begin
              ram_addr <= {ram_addr[ADDR_W-1:2], iss_lane + 2'd1};
              iss_lane <= iss_lane + 2'd1;
            end
          end
          // Lanes return in ascending order, so shifting in from the top assembles the word.
          if (tag_out.valid) begin
            rd_buf <= {ram_rdata, rd_buf[23:8]};
            if (tag_out.lane == 2'd3) rsp_rdata <= {ram_rdata, rd_buf};
          end
        end
        DMEM_WR: begin
          if (wr_mask != '0) begin
            ram_addr  <= {ram_addr[ADDR_W-1:2], wr_lane};
            ram_we    <= 1'b1;
            ram_wdata <= lane_byte(req_wdata, wr_lane);
            wr_mask   <= wr_mask & ~lane_bit(wr_lane);
          end
        end
        DMEM_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomised self-checking bench: two bridges (RAM_LAT 1 and 3) against a spec-level memory model.
module tb_data_mem_bridge;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned MEM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  logic              req_ce    [2];
  logic              req_we    [2];
  logic [31:0]       req_addr  [2];
  logic [3:0]        req_sel   [2];
  logic [31:0]       req_wdata [2];
  logic [31:0]       rsp_rdata [2];
  logic              rsp_ack   [2];
  logic              rsp_fault [2];
  logic              stall_req [2];
  logic [ADDR_W-1:0] ram_addr  [2];
  logic              ram_we    [2];
  logic [7:0]        ram_wdata [2];
  logic [7:0]        ram_rdata [2];

  logic [7:0]  ram     [2][MEM_SZ];
  logic [7:0]  ref_mem [2][MEM_SZ];
  logic [31:0] exp_rdata [2];
  logic [7:0]  rd_lat1;
  logic [7:0]  rd_lat3 [3];
  int unsigned lat_of  [2] = '{1, 3};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_bridge #(.ADDR_W(ADDR_W), .RAM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .req_ce(req_ce[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_sel(req_sel[0]), .req_wdata(req_wdata[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_ack(rsp_ack[0]), .rsp_fault(rsp_fault[0]),
    .stall_req(stall_req[0]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0])
  );

  data_mem_bridge #(.ADDR_W(ADDR_W), .RAM_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .req_ce(req_ce[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_sel(req_sel[1]), .req_wdata(req_wdata[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_ack(rsp_ack[1]), .rsp_fault(rsp_fault[1]),
    .stall_req(stall_req[1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1])
  );

  // Byte-wide synchronous RAMs with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    if (ram_we[0]) ram[0][ram_addr[0]] <= ram_wdata[0];
    if (ram_we[1]) ram[1][ram_addr[1]] <= ram_wdata[1];
    rd_lat1    <= ram[0][ram_addr[0]];
    rd_lat3[0] <= ram[1][ram_addr[1]];
    rd_lat3[1] <= rd_lat3[0];
    rd_lat3[2] <= rd_lat3[1];
  end

  assign ram_rdata[0] = rd_lat1;
  assign ram_rdata[1] = rd_lat3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_fault(input logic we, input logic [31:0] addr, input logic [3:0] sel);
    logic f;
    f = 1'b0;
`ifdef DMEM_FAULT_EN
    if (addr[31:ADDR_W] != '0) f = 1'b1;
    if (we && !(sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
      f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input int n);
    logic [31:0] sh;
    sh = word >> (8 * n);
    return sh[7:0];
  endfunction

  task automatic run_txn(input int unsigned d, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
    logic              flt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    int unsigned       exp_lat, ack_cyc, stall_err, addr_err;
    bit                acked;
    logic [31:0]       exp_w [$];
    logic [31:0]       got_w [$];

    flt  = exp_fault(we, addr, sel);
    base = {addr[ADDR_W-1:2], 2'b00};
    if (flt)      exp_lat = 1;
    else if (!we) exp_lat = 5 + lat_of[d];
    else          exp_lat = 1 + $countones(sel);

    if (!flt && !we)
      exp_rdata[d] = {ref_mem[d][base + 3], ref_mem[d][base + 2],
                      ref_mem[d][base + 1], ref_mem[d][base]};
    if (!flt && we) begin
      for (int n = 0; n < 4; n++) begin
        if (sel[n]) begin
          a = base + ADDR_W'(n);
          exp_w.push_back({7'(exp_w.size() + 1), a, byte_of(wdata, n)});
          ref_mem[d][a] = byte_of(wdata, n);
        end
      end
    end

    @(negedge clk);
    req_ce[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_sel[d] = sel; req_wdata[d] = wdata;
    acked = 0; ack_cyc = 0; stall_err = 0; addr_err = 0;
    for (int unsigned cyc = 0; cyc < 24 && !acked; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (ram_we[d]) got_w.push_back({7'(cyc), ram_addr[d], ram_wdata[d]});
      if (!we && !flt && cyc >= 1 && cyc <= 4 && ram_addr[d] !== base + ADDR_W'(cyc - 1))
        addr_err++;
      if (rsp_ack[d]) begin
        acked   = 1;
        ack_cyc = cyc;
        if (stall_req[d] !== 1'b0) stall_err++;
      end else if (stall_req[d] !== 1'b1) begin
        stall_err++;
      end
    end

    check_eq("ack_latency", acked ? ack_cyc : 32'hFFFF_FFFF, exp_lat);
    check_eq("stall_req", stall_err, 0);
    if (acked) begin
      check_eq("rsp_fault", {31'd0, rsp_fault[d]}, {31'd0, flt});
      check_eq("rsp_rdata", rsp_rdata[d], exp_rdata[d]);
    end
    req_ce[d] = 1'b0;

    check_eq("write_count", got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check_eq("write_trace", got_w[i], exp_w[i]);
    if (!we && !flt) check_eq("read_addr_seq", addr_err, 0);
    if (we && !flt)
      for (int n = 0; n < 4; n++)
        check_eq("mem_byte", {24'd0, ram[d][base + ADDR_W'(n)]}, {24'd0, ref_mem[d][base + ADDR_W'(n)]});
  endtask

  task automatic reset_mid_store(input int unsigned d, input logic [31:0] addr, input logic [31:0] wdata);
    logic [ADDR_W-1:0] base;
    int unsigned       acks;
    base = {addr[ADDR_W-1:2], 2'b00};

    @(negedge clk);
    req_ce[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = addr;
    req_sel[d] = 4'b1111; req_wdata[d] = wdata;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_ce[d] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ram_we", {31'd0, ram_we[d]}, 32'd0);
    check_eq("rst_ram_addr", {15'd0, ram_addr[d]}, 32'd0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (rsp_ack[d]) acks++;
    end
    check_eq("rst_no_ack", acks, 0);

    for (int n = 0; n < 2; n++) ref_mem[d][base + ADDR_W'(n)] = byte_of(wdata, n);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    check_eq("rst_rdata_cleared", rsp_rdata[d], 32'd0);
    for (int n = 0; n < 4; n++)
      check_eq("rst_mem_byte", {24'd0, ram[d][base + ADDR_W'(n)]}, {24'd0, ref_mem[d][base + ADDR_W'(n)]});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_ce[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_sel[d] = '0; req_wdata[d] = '0; exp_rdata[d] = '0;
    end
    for (int i = 0; i < MEM_SZ; i++) begin
      ram[0][i] <= 8'h00; ram[1][i] <= 8'h00;
      ref_mem[0][i] = 8'h00; ref_mem[1][i] = 8'h00;
    end
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        ram[d][ADDR_W'(32'h100 + k)]     <= 8'(8'h11 * (k + 1));
        ref_mem[d][ADDR_W'(32'h100 + k)]  = 8'(8'h11 * (k + 1));
      end

    repeat (3) @(negedge clk);
    #1;
    for (int unsigned d = 0; d < 2; d++) begin
      check_eq("reset_rdata", rsp_rdata[d], 32'd0);
      check_eq("reset_ack", {31'd0, rsp_ack[d]}, 32'd0);
      check_eq("reset_fault", {31'd0, rsp_fault[d]}, 32'd0);
      check_eq("reset_ram_addr", {15'd0, ram_addr[d]}, 32'd0);
      check_eq("reset_ram_we", {31'd0, ram_we[d]}, 32'd0);
      check_eq("reset_ram_wdata", {24'd0, ram_wdata[d]}, 32'd0);
      check_eq("reset_stall", {31'd0, stall_req[d]}, 32'd0);
    end
    rst = 1'b0;

    for (int unsigned d = 0; d < 2; d++) begin
      run_txn(d, 1'b0, 32'h0000_0102, 4'b0000, 32'h0);
      check_eq("load_0x100_word", rsp_rdata[d], 32'h4433_2211);
      run_txn(d, 1'b1, 32'h0000_0205, 4'b0010, 32'hA5A5_A5A5);
      run_txn(d, 1'b1, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF);
      run_txn(d, 1'b0, 32'h0000_0040, 4'b0000, 32'h0);
      check_eq("reload_deadbeef", rsp_rdata[d], 32'hDEAD_BEEF);
      reset_mid_store(d, 32'h0000_0080, 32'h0102_0304);
      run_txn(d, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
      run_txn(d, 1'b1, 32'h0000_0300, 4'b0110, 32'h1234_5678);
      run_txn(d, 1'b0, 32'hFFFF_0000, 4'b0000, 32'h0);
      run_txn(d, 1'b1, 32'h0000_0310, 4'b0000, 32'hFFFF_FFFF);
    end

    for (int i = 0; i < 120; i++) begin
      addr = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000 | ($urandom & 32'hFFFE_0000);
      run_txn(i % 2, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
